matmul_lane_engine: RTL and testbench

// - Computes C = A x B for square NxN matrices using LANES parallel MAC lanes.

---
 rtl/matmul_pkg.sv | 27 ++
 rtl/mac_lane.sv | 34 +++
 rtl/matmul_lane_engine.sv | 209 ++++++++++++++++++++
 tb/tb_matmul_lane_engine.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// rtl/matmul_pkg.sv - shared state encoding and width helpers for the lane matmul engine
package matmul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH,
    ST_DONE
  } state_t;

  function automatic int clog2i(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

  function automatic int calc_aw(input int n);
    return clog2i(n * n);
  endfunction

  // Wide enough that N full-scale products summed never overflow.
  function automatic int calc_accw(input int n, input int dw);
    return 2 * dw + clog2i(n);
  endfunction

endpackage

// File: rtl/mac_lane.sv
// rtl/mac_lane.sv - one multiply-accumulate lane; load replaces the sum, en gates any update
module mac_lane #(
  parameter int DW     = 8,
  parameter int ACCW   = 19,
  parameter int SIGNED = 1
) (
  input  logic            clk,
  input  logic            load,
  input  logic            en,
  input  logic [DW-1:0]   a,
  input  logic [DW-1:0]   b,
  output logic [ACCW-1:0] acc
);

  logic signed [DW:0]     a_ext;
  logic signed [DW:0]     b_ext;
  logic signed [2*DW+1:0] prod;
  logic [ACCW-1:0]        prod_w;

  // One extra operand bit lets a single signed multiplier serve both modes.
  always_comb begin
    a_ext  = (SIGNED != 0) ? {a[DW-1], a} : {1'b0, a};
    b_ext  = (SIGNED != 0) ? {b[DW-1], b} : {1'b0, b};
    prod   = a_ext * b_ext;
    prod_w = ACCW'(prod);
  end

  always_ff @(posedge clk) begin
    if (en) begin
      acc <= load ? prod_w : acc + prod_w;
    end
  end

endmodule

// File: rtl/matmul_lane_engine.sv
// rtl/matmul_lane_engine.sv - C = A x B over LANES MAC lanes with serial C drain
module matmul_lane_engine
  import matmul_pkg::*;
#(
  parameter int N      = 8,
  parameter int DW     = 8,
  parameter int LANES  = 2,
  parameter int SIGNED = 1,
  localparam int AW    = calc_aw(N),
  localparam int ACCW  = calc_accw(N, DW)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [15:0]         cycle_count,
  output logic [LANES*AW-1:0] a_raddr,
  input  logic [LANES*DW-1:0] a_rdata,
  output logic [AW-1:0]       b_raddr,
  input  logic [DW-1:0]       b_rdata,
  output logic                c_we,
  output logic [AW-1:0]       c_waddr,
  output logic [ACCW-1:0]     c_wdata
);

  localparam int KW = clog2i(N);
  localparam int G  = N / LANES;
  localparam int GW = (G > 1) ? clog2i(G) : 1;
  localparam int LW = (LANES > 1) ? clog2i(LANES) : 1;

  state_t state, state_nx;

  logic [KW-1:0] k_q, j_q, k_nx, j_nx, iss_k, iss_j;
  logic [GW-1:0] g_q, g_nx, iss_g;
  logic          k_last, g_last, issue_last, advance;

  logic          s1_valid, s1_first, s1_last, s1_final;
  logic [GW-1:0] s1_g;
  logic [KW-1:0] s1_j;

  logic            drain_active, drain_final, drain_end;
  logic [LW-1:0]   drain_idx;
  logic [ACCW-1:0] drain_buf [LANES];
  logic [ACCW-1:0] acc [LANES];

  logic [15:0] run_cnt, cnt_inc;

  function automatic logic [AW-1:0] a_addr(input logic [GW-1:0] g, input int l,
                                           input logic [KW-1:0] k);
    int v;
    v = (int'(g) * LANES + l) * N + int'(k);
    return v[AW-1:0];
  endfunction

  function automatic logic [AW-1:0] b_addr(input logic [KW-1:0] k, input logic [KW-1:0] j);
    int v;
    v = int'(k) * N + int'(j);
    return v[AW-1:0];
  endfunction

  // Issue counter: column j outer, row group g middle, k inner.
  always_comb begin
    k_last     = (k_q == KW'(N - 1));
    g_last     = (g_q == GW'(G - 1));
    issue_last = k_last && g_last && (j_q == KW'(N - 1));
    k_nx       = k_q + 1'b1;
    g_nx       = g_q;
    j_nx       = j_q;
    if (k_last) begin
      g_nx = g_last ? '0 : g_q + 1'b1;
      if (g_last) j_nx = j_q + 1'b1;
    end
    advance = (state == ST_RUN) || ((state == ST_IDLE) && start);
    iss_k   = (state == ST_IDLE) ? '0 : k_nx;
    iss_g   = (state == ST_IDLE) ? '0 : g_nx;
    iss_j   = (state == ST_IDLE) ? '0 : j_nx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      k_q     <= '0;
      g_q     <= '0;
      j_q     <= '0;
      a_raddr <= '0;
      b_raddr <= '0;
    end else if (advance) begin
      k_q     <= iss_k;
      g_q     <= iss_g;
      j_q     <= iss_j;
      for (int l = 0; l < LANES; l++) begin
        a_raddr[l*AW +: AW] <= a_addr(iss_g, l, iss_k);
      end
      b_raddr <= b_addr(iss_k, iss_j);
    end
  end

  // Issue tags travel one cycle to line up with the RAM read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_final <= 1'b0;
      s1_g     <= '0;
      s1_j     <= '0;
    end else begin
      s1_valid <= (state == ST_RUN);
      s1_first <= (k_q == '0);
      s1_last  <= k_last;
      s1_final <= issue_last;
      s1_g     <= g_q;
      s1_j     <= j_q;
    end
  end

  // Reset forces a zero-product load so the accumulators clear without a reset port.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [DW-1:0] lane_a;
    assign lane_a = a_rdata[l*DW +: DW] & {DW{~reset}};
    mac_lane #(
      .DW    (DW),
      .ACCW  (ACCW),
      .SIGNED(SIGNED)
    ) u_mac (
      .clk (clk),
      .load(reset | s1_first),
      .en  (reset | s1_valid),
      .a   (lane_a),
      .b   (b_rdata),
      .acc (acc[l])
    );
  end

  // Lane 0 drains straight from its accumulator; the rest from the snapshot
  // taken while the finished sums are still held, before the next group's load lands.
  assign drain_end = drain_active && (drain_idx == LW'(LANES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      drain_active <= 1'b0;
      drain_final  <= 1'b0;
      drain_idx    <= '0;
      c_waddr      <= '0;
      for (int l = 0; l < LANES; l++) drain_buf[l] <= '0;
    end else begin
      if (drain_active && (drain_idx == '0)) begin
        for (int l = 0; l < LANES; l++) drain_buf[l] <= acc[l];
      end
      if (s1_valid && s1_last) begin
        drain_active <= 1'b1;
        drain_final  <= s1_final;
        drain_idx    <= '0;
        c_waddr      <= a_addr(s1_g, 0, s1_j);
      end else if (drain_active) begin
        if (drain_end) begin
          drain_active <= 1'b0;
        end else begin
          drain_idx <= drain_idx + 1'b1;
          c_waddr   <= c_waddr + AW'(N);
        end
      end
    end
  end

  assign c_wdata = (drain_idx == '0) ? acc[0] : drain_buf[drain_idx];

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    c_we     = drain_active;
    case (state)
      ST_IDLE:  if (start) state_nx = ST_RUN;
      ST_RUN: begin
        busy = 1'b1;
        if (issue_last) state_nx = ST_FLUSH;
      end
      ST_FLUSH: begin
        busy = 1'b1;
        if (drain_end && drain_final) state_nx = ST_DONE;
      end
      ST_DONE: begin
        done     = 1'b1;
        state_nx = ST_IDLE;
      end
      default:  state_nx = ST_IDLE;
    endcase
  end

  assign cnt_inc = (run_cnt == 16'hFFFF) ? run_cnt : run_cnt + 16'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      run_cnt     <= '0;
      cycle_count <= '0;
    end else begin
      if ((state == ST_IDLE) && start) run_cnt <= '0;
      else if (busy)                   run_cnt <= cnt_inc;
      if ((state == ST_FLUSH) && (state_nx == ST_DONE)) cycle_count <= cnt_inc;
    end
  end

endmodule

// File: tb/tb_matmul_lane_engine.sv
// tb/tb_matmul_lane_engine.sv - self-checking bench over five engine configurations
module tb_matmul_lane_engine;

  localparam int N    = 8;
  localparam int DW   = 8;
  localparam int AW   = 6;
  localparam int ACCW = 19;
  localparam int NI   = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic start_v [NI];
  logic clr_req [NI];
  logic busy_v [NI], done_v [NI], c_we_v [NI], a_zero_v [NI];
  logic [15:0]     cc_v [NI];
  logic [AW-1:0]   c_waddr_v [NI], b_raddr_v [NI];
  logic [ACCW-1:0] c_wdata_v [NI];

  logic [DW-1:0]   amem [64];
  logic [DW-1:0]   bmem [64];
  logic [ACCW-1:0] cmem [NI][64];
  logic            written [NI][64];
  int wcnt [NI], dupcnt [NI], donecnt [NI];

  int tests = 0;
  int fails = 0;

  function automatic int lanes_of(input int i);
    case (i)
      2:       return 1;
      3:       return 4;
      4:       return 8;
      default: return 2;
    endcase
  endfunction

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    localparam int LN = lanes_of(gi);
    localparam int SG = (gi == 1) ? 0 : 1;
    logic [LN*AW-1:0] a_raddr;
    logic [LN*DW-1:0] a_rdata;
    logic [AW-1:0]    b_raddr, c_waddr;
    logic [DW-1:0]    b_rdata;
    logic             busy, done, c_we;
    logic [15:0]      cycle_count;
    logic [ACCW-1:0]  c_wdata;

    matmul_lane_engine #(.N(N), .DW(DW), .LANES(LN), .SIGNED(SG)) u_dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start_v[gi]),
      .busy       (busy),
      .done       (done),
      .cycle_count(cycle_count),
      .a_raddr    (a_raddr),
      .a_rdata    (a_rdata),
      .b_raddr    (b_raddr),
      .b_rdata    (b_rdata),
      .c_we       (c_we),
      .c_waddr    (c_waddr),
      .c_wdata    (c_wdata)
    );

    always @(posedge clk) begin
      for (int l = 0; l < LN; l++) a_rdata[l*DW +: DW] <= amem[a_raddr[l*AW +: AW]];
      b_rdata <= bmem[b_raddr];
    end

    assign busy_v[gi]    = busy;
    assign done_v[gi]    = done;
    assign c_we_v[gi]    = c_we;
    assign cc_v[gi]      = cycle_count;
    assign c_waddr_v[gi] = c_waddr;
    assign c_wdata_v[gi] = c_wdata;
    assign b_raddr_v[gi] = b_raddr;
    assign a_zero_v[gi]  = (a_raddr == '0);
  end

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (clr_req[i]) begin
        wcnt[i]    <= 0;
        dupcnt[i]  <= 0;
        donecnt[i] <= 0;
        for (int a = 0; a < 64; a++) written[i][a] <= 1'b0;
      end else begin
        if (c_we_v[i]) begin
          if (written[i][c_waddr_v[i]]) dupcnt[i] <= dupcnt[i] + 1;
          written[i][c_waddr_v[i]] <= 1'b1;
          cmem[i][c_waddr_v[i]]    <= c_wdata_v[i];
          wcnt[i]                  <= wcnt[i] + 1;
        end
        if (done_v[i]) donecnt[i] <= donecnt[i] + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Plain textbook dot product, truncated to the result port width.
  function automatic logic [ACCW-1:0] ref_c(input int i, input int j, input int sg);
    longint s, av, bv;
    s = 0;
    for (int k = 0; k < N; k++) begin
      av = sg ? longint'($signed(amem[i*N+k])) : longint'(amem[i*N+k]);
      bv = sg ? longint'($signed(bmem[k*N+j])) : longint'(bmem[k*N+j]);
      s  = s + av * bv;
    end
    return s[ACCW-1:0];
  endfunction

  task automatic run(input int idx, input int mid_start, input int done_start, output int blen);
    int n;
    clr_req[idx] = 1'b1;
    start_v[idx] = 1'b1;
    @(negedge clk);
    clr_req[idx] = 1'b0;
    start_v[idx] = 1'b0;
    n = 0;
    while (busy_v[idx] && n < 5000) begin
      n++;
      start_v[idx] = (mid_start != 0) && (n == 51);
      @(negedge clk);
    end
    start_v[idx] = 1'b0;
    blen = n;
    chk("done_pulse", done_v[idx], 1);
    chk("done_busy_low", busy_v[idx], 0);
    if (done_start) start_v[idx] = 1'b1;
    @(negedge clk);
    start_v[idx] = 1'b0;
    chk("done_clear", done_v[idx], 0);
    chk("idle_after_done", busy_v[idx], 0);
  endtask

  task automatic check_run(input int idx, input int sg, input int blen);
    int exp_len;
    exp_len = 512 / lanes_of(idx) + lanes_of(idx) + 1;
    chk("busy_len", blen, exp_len);
    chk("cycle_count", cc_v[idx], exp_len);
    chk("write_count", wcnt[idx], 64);
    chk("dup_writes", dupcnt[idx], 0);
    chk("done_count", donecnt[idx], 1);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        chk($sformatf("c_%0d_%0d_inst%0d", i, j, idx), cmem[idx][i*N+j], ref_c(i, j, sg));
  endtask

  task automatic fill_random();
    for (int a = 0; a < 64; a++) begin
      amem[a] = DW'($urandom);
      bmem[a] = DW'($urandom);
    end
  endtask

  initial begin
    int blen, w, cc_first;
    int order [5];
    logic [ACCW-1:0] snap [64];

    reset = 1'b1;
    for (int i = 0; i < NI; i++) begin
      start_v[i] = 1'b0;
      clr_req[i] = 1'b0;
    end
    for (int a = 0; a < 64; a++) begin
      amem[a] = '0;
      bmem[a] = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk("rst_busy", busy_v[i], 0);
      chk("rst_done", done_v[i], 0);
      chk("rst_c_we", c_we_v[i], 0);
      chk("rst_cycle_count", cc_v[i], 0);
      chk("rst_a_raddr_zero", a_zero_v[i], 1);
      chk("rst_b_raddr", b_raddr_v[i], 0);
      chk("rst_c_waddr", c_waddr_v[i], 0);
    end
    reset = 1'b0;
    @(negedge clk);

    // Identity A, ramp B: C must equal B.
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) begin
        amem[i*N+k] = (i == k) ? 8'd1 : 8'd0;
        bmem[i*N+k] = DW'(i * N + k);
      end
    run(0, 0, 0, blen);
    check_run(0, 1, blen);
    chk("identity_c_5_3", cmem[0][43], 43);
    chk("identity_cc_259", cc_v[0], 259);

    // Most-negative operands, signed and unsigned views.
    for (int a = 0; a < 64; a++) begin
      amem[a] = 8'h80;
      bmem[a] = 8'h80;
    end
    run(0, 0, 0, blen);
    check_run(0, 1, blen);
    chk("extreme_signed", cmem[0][63], 131072);
    run(1, 0, 0, blen);
    check_run(1, 0, blen);
    chk("extreme_unsigned", cmem[1][0], 131072);

    // Random data across lane counts 1, 2, 4, 8 and the unsigned build.
    order = '{2, 0, 3, 4, 1};
    foreach (order[o]) begin
      fill_random();
      run(order[o], 0, 0, blen);
      check_run(order[o], (order[o] == 1) ? 0 : 1, blen);
    end

    // Reset at busy cycle 100, then a full restart.
    fill_random();
    clr_req[0] = 1'b1;
    start_v[0] = 1'b1;
    @(negedge clk);
    clr_req[0] = 1'b0;
    start_v[0] = 1'b0;
    repeat (100) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_busy", busy_v[0], 0);
    chk("midrst_c_we", c_we_v[0], 0);
    w = wcnt[0];
    repeat (30) @(negedge clk);
    chk("midrst_no_writes", wcnt[0], w);
    chk("midrst_no_done", donecnt[0], 0);
    chk("midrst_still_idle", busy_v[0], 0);
    run(0, 0, 0, blen);
    check_run(0, 1, blen);

    // Start pulses while busy and on the done cycle are ignored.
    fill_random();
    run(0, 1, 1, blen);
    check_run(0, 1, blen);

    // Back-to-back runs on the 4-lane engine.
    fill_random();
    run(3, 0, 0, blen);
    check_run(3, 1, blen);
    cc_first = cc_v[3];
    for (int a = 0; a < 64; a++) snap[a] = cmem[3][a];
    run(3, 0, 0, blen);
    check_run(3, 1, blen);
    chk("b2b_cycle_count", cc_v[3], cc_first);
    for (int a = 0; a < 64; a++) chk($sformatf("b2b_c_%0d", a), cmem[3][a], snap[a]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
